// File: rtl/lsu_bus_master.sv
// lsu_bus_master: single-outstanding load/store initiator for the system bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module lsu_bus_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write_data,
  output logic        bus_enable,
  output logic        bus_is_write,
  output logic [3:0]  bus_byte_sel,
  input  logic [31:0] bus_data_in
);

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_e;
`endif

  localparam logic [2:0] WAIT_EN = 3'(READ_LATENCY - 1);

  state_e      state_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        write_q;
  logic [1:0]  off_q;
  logic [2:0]  cnt_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic        bus_enable_q;
  logic        bus_is_write_q;
  logic [3:0]  bus_byte_sel_q;
  logic [31:0] raw_data;

  function automatic logic [3:0] lanes(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    case (sz)
      2'b00:   lanes = 4'b0001 << a;
      2'b01:   lanes = 4'b0011 << {a[1], 1'b0};
      default: lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wrep(
    input logic [1:0]  sz,
    input logic [31:0] wd
  );
    case (sz)
      2'b00:   wrep = {4{wd[7:0]}};
      2'b01:   wrep = {2{wd[15:0]}};
      default: wrep = wd;
    endcase
  endfunction

  function automatic logic [1:0] offs(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    case (sz)
      2'b00:   offs = a;
      2'b01:   offs = {a[1], 1'b0};
      default: offs = 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] extend(
    input logic [31:0] raw,
    input logic [1:0]  sz,
    input logic        uns
  );
    case (sz)
      2'b00:   extend = {{24{raw[7] & ~uns}}, raw[7:0]};
      2'b01:   extend = {{16{raw[15] & ~uns}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misal(
    input logic [1:0] sz,
    input logic [1:0] a
  );
    misal = ((sz == 2'b01) && a[0]) ||
            (sz[1] && (a != 2'b00));
  endfunction

  logic resp_err_q;
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // The arbiter muxes data_out on addr, so bus_addr stays put until capture.
  assign raw_data = bus_data_in >> {off_q, 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      size_q         <= 2'b00;
      uns_q          <= 1'b0;
      write_q        <= 1'b0;
      off_q          <= 2'b00;
      cnt_q          <= 3'd0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_enable_q   <= 1'b0;
      bus_is_write_q <= 1'b0;
      bus_byte_sel_q <= 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err_q     <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      resp_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            write_q <= req_write;
            off_q   <= offs(req_size, req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
            if (misal(req_size, req_addr[1:0])) begin
              state_q      <= ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else
`endif
            begin
              state_q        <= ISSUE;
              bus_enable_q   <= 1'b1;
              bus_is_write_q <= req_write;
              bus_addr_q     <= {req_addr[31:2], 2'b00};
              bus_byte_sel_q <= lanes(req_size, req_addr[1:0]);
              bus_wdata_q    <= req_write ?
                                wrep(req_size, req_wdata) : '0;
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
            state_q        <= RESP;
            resp_valid_q   <= 1'b1;
            resp_rdata_q   <= '0;
            bus_enable_q   <= 1'b0;
            bus_is_write_q <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_byte_sel_q <= 4'b0000;
          end else begin
            state_q        <= WAIT;
            cnt_q          <= WAIT_EN;
            bus_enable_q   <= (WAIT_EN != 3'd0);
            bus_is_write_q <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q        <= cnt_q - 3'd1;
            bus_enable_q <= (cnt_q != 3'd1);
          end else begin
            state_q        <= RESP;
            resp_valid_q   <= 1'b1;
            resp_rdata_q   <= extend(raw_data, size_q, uns_q);
            bus_enable_q   <= 1'b0;
            bus_is_write_q <= 1'b0;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_byte_sel_q <= 4'b0000;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_rdata_q <= '0;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        ERR: begin
          state_q      <= IDLE;
          resp_rdata_q <= '0;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign bus_addr       = bus_addr_q;
  assign bus_write_data = bus_wdata_q;
  assign bus_enable     = bus_enable_q;
  assign bus_is_write   = bus_is_write_q;
  assign bus_byte_sel   = bus_byte_sel_q;

endmodule
